// File: rtl/tag_pkg.sv
// Shared definitions for the tag issuer and the tag-buffer columns it serves.
package tag_pkg;

    // Issue-sequence states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } tag_state_e;

    // Tag width: one more bit than needed to index the columns, so tag value
    // NUM_COL is representable and 0 stays reserved as the "no tag" value.
    function automatic int unsigned tag_width(input int unsigned num_col);
        return $clog2(num_col) + 1;
    endfunction

endpackage

// File: rtl/tag_issuer_if.sv
// Sequencer/column bus of the tag issuer: request side, broadcast tag and lock status.
interface tag_issuer_if #(
    parameter int unsigned NUM_COL = 4,
    parameter int unsigned TAG_W   = tag_pkg::tag_width(NUM_COL)
);
    logic               start;
    logic [TAG_W-1:0]   num_tags;
    logic               abort;
    logic [NUM_COL-1:0] tag_lock_in;
    logic               flush_tag;
    logic [TAG_W-1:0]   tag_out;
    logic               busy;
    logic               done;
    logic               err;

    // Requester / column model side.
    modport master (
        output start, num_tags, abort, tag_lock_in,
        input  flush_tag, tag_out, busy, done, err
    );

    // Issuer side.
    modport slave (
        input  start, num_tags, abort, tag_lock_in,
        output flush_tag, tag_out, busy, done, err
    );
endinterface

// File: rtl/tag_timer.sv
// Wait counter for one column lock, with terminal-count detection.
module tag_timer #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic en,
    output logic expired
);
    localparam int unsigned CNT_W = $clog2(LIMIT) + 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    // Next count: clear wins over enable.
    always_comb begin
        cnt_inc = cnt_q + CNT_W'(1);
        cnt_d   = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_inc;
        end
    end

    // Expiry flags the cycle in which this increment reaches LIMIT-1.
    assign expired = en && !clear && (cnt_inc == CNT_W'(LIMIT - 1));

    // Count register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/tag_issuer.sv
// Issues tags 1..N to all columns, one at a time, waiting for each column lock.
module tag_issuer
    import tag_pkg::*;
#(
    parameter  int unsigned NUM_COL = 4,
    parameter  int unsigned TIMEOUT = 16,
    localparam int unsigned TAG_W   = tag_width(NUM_COL)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic [TAG_W-1:0]   num_tags,
    input  logic               abort,
    input  logic [NUM_COL-1:0] tag_lock_in,
    output logic               flush_tag,
    output logic [TAG_W-1:0]   tag_out,
    output logic               busy,
    output logic               done,
    output logic               err
);
    localparam logic [TAG_W-1:0] MAX_TAGS = TAG_W'(NUM_COL);

    tag_state_e       state_q, state_d;
    logic [TAG_W-1:0] cur_tag_q, cur_tag_d;
    logic [TAG_W-1:0] n_q, n_d;
    logic [TAG_W-1:0] tag_out_q, tag_out_d;
    logic             flush_tag_q, flush_tag_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             lock_hit;
    logic             timer_clear;
    logic             timer_en;
    logic             timer_expired;

    // Only the lock bit of the column matching the current tag matters.
    assign lock_hit    = |(tag_lock_in & (NUM_COL'(1) << (cur_tag_q - TAG_W'(1))));
    assign timer_clear = (state_q == ST_ISSUE);
    assign timer_en    = (state_q == ST_WAIT) && !lock_hit && !abort;

    tag_timer #(
        .LIMIT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rstn    (rstn),
        .clear   (timer_clear),
        .en      (timer_en),
        .expired (timer_expired)
    );

    // Next state and next output values; outputs are registered against the
    // next state so each strobe lines up with the state it belongs to.
    always_comb begin
        state_d     = state_q;
        cur_tag_d   = cur_tag_q;
        n_d         = n_q;
        tag_out_d   = tag_out_q;
        flush_tag_d = 1'b0;
        done_d      = 1'b0;
        err_d       = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    n_d       = (num_tags > MAX_TAGS) ? MAX_TAGS : num_tags;
                    cur_tag_d = TAG_W'(1);
                    err_d     = 1'b0;
                    if (n_d == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = ST_ISSUE;
                        flush_tag_d = 1'b1;
                        tag_out_d   = TAG_W'(1);
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (lock_hit) begin
                    if (cur_tag_q == n_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        cur_tag_d   = cur_tag_q + TAG_W'(1);
                        state_d     = ST_ISSUE;
                        flush_tag_d = 1'b1;
                        tag_out_d   = cur_tag_d;
                    end
                end else if (timer_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides whatever the state decided above, including a
        // lock or timeout seen in the same cycle.
        if (abort && (state_q != ST_IDLE)) begin
            state_d     = ST_IDLE;
            cur_tag_d   = cur_tag_q;
            tag_out_d   = tag_out_q;
            flush_tag_d = 1'b0;
            done_d      = 1'b0;
            err_d       = err_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State, tag counter and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            cur_tag_q   <= '0;
            n_q         <= '0;
            tag_out_q   <= '0;
            flush_tag_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_tag_q   <= cur_tag_d;
            n_q         <= n_d;
            tag_out_q   <= tag_out_d;
            flush_tag_q <= flush_tag_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign flush_tag = flush_tag_q;
    assign tag_out   = tag_out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
endmodule

// File: tb/tb_tag_issuer.sv
// Self-checking bench for tag_issuer: directed scenarios plus random sequences
// against a timeline model of the issue protocol.
module tb_tag_issuer;
    import tag_pkg::*;

    localparam int unsigned NUM_COL = 4;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned TAG_W   = tag_width(NUM_COL);

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    tag_issuer_if #(.NUM_COL(NUM_COL)) bus ();

    tag_issuer #(
        .NUM_COL (NUM_COL),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (bus.start),
        .num_tags    (bus.num_tags),
        .abort       (bus.abort),
        .tag_lock_in (bus.tag_lock_in),
        .flush_tag   (bus.flush_tag),
        .tag_out     (bus.tag_out),
        .busy        (bus.busy),
        .done        (bus.done),
        .err         (bus.err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected timeline of one sequence, in absolute cycle numbers.
    int exp_fc[$];
    int exp_ft[$];
    int exp_done;
    int exp_err;
    int exp_end;
    int exp_abort;
    int model_last_tag = 0;

    // Start seen in cycle T. Tag t flushed at F gets its lock in F+d; a lock
    // within TIMEOUT-1 waiting cycles moves on at F+d+1, otherwise the
    // sequence gives up at F+TIMEOUT with err. Abort at X cancels all later events.
    task automatic model(input int T, input int nt, input int dl[4], input int abort_tag);
        int  n, f, m;
        bit  fin;
        n = (nt > int'(NUM_COL)) ? int'(NUM_COL) : nt;
        exp_fc.delete();
        exp_ft.delete();
        exp_done  = -1;
        exp_err   = 0;
        exp_abort = -1;
        exp_end   = T + 1;
        if (n == 0) begin
            exp_done = T + 1;
            exp_end  = T + 1;
        end else begin
            f   = T + 1;
            fin = 1'b0;
            for (int t = 1; t <= n; t++) begin
                if (!fin) begin
                    exp_fc.push_back(f);
                    exp_ft.push_back(t);
                    if (dl[t-1] >= 1 && dl[t-1] <= int'(TIMEOUT) - 1) begin
                        m = f + dl[t-1];
                        if (t == abort_tag) exp_abort = m;
                        if (t == n) begin
                            exp_done = m + 1;
                            exp_end  = m + 1;
                            fin      = 1'b1;
                        end else begin
                            f = m + 1;
                        end
                    end else begin
                        exp_err  = 1;
                        exp_done = f + int'(TIMEOUT);
                        exp_end  = exp_done;
                        fin      = 1'b1;
                    end
                end
            end
        end
        if (exp_abort >= 0) begin
            while (exp_fc.size() > 0 && exp_fc[$] > exp_abort) begin
                void'(exp_fc.pop_back());
                void'(exp_ft.pop_back());
            end
            exp_done = -1;
            exp_err  = 0;
            exp_end  = exp_abort;
        end
        if (exp_ft.size() > 0) model_last_tag = exp_ft[$];
    endtask

    // One sequence: drive start, act as the columns (lock tag t dl[t-1] cycles
    // after its flush; 0 = never), optionally abort together with a lock.
    task automatic run_seq(input string name, input int nt, input int dl[4], input int abort_tag);
        int T, c, n, busy_cnt, done_cnt, done_cyc, tg;
        int obs_fc[$];
        int obs_ft[$];
        int sched[4];
        n = (nt > int'(NUM_COL)) ? int'(NUM_COL) : nt;
        @(negedge clk);
        T = cyc;
        bus.num_tags    = TAG_W'(nt);
        bus.start       = 1'b1;
        bus.abort       = 1'b0;
        bus.tag_lock_in = '0;
        model(T, nt, dl, abort_tag);
        for (int i = 0; i < 4; i++) sched[i] = -1;
        busy_cnt = 0;
        done_cnt = 0;
        done_cyc = -1;
        do begin
            @(negedge clk);
            c = cyc;
            bus.abort = 1'b0;
            if (c == T + 1) begin
                bus.start = 1'b0;
                check_eq({name, " err_after_start"}, bus.err, 0);
            end
            if (c == T + 2 && exp_end >= T + 2) begin
                bus.start    = 1'b1;
                bus.num_tags = TAG_W'($urandom_range(0, 7));
            end
            if (c == T + 3) bus.start = 1'b0;
            if (bus.flush_tag) begin
                tg = int'(bus.tag_out);
                obs_fc.push_back(c);
                obs_ft.push_back(tg);
                if (tg >= 1 && tg <= int'(NUM_COL) && dl[tg-1] >= 1) sched[tg-1] = c + dl[tg-1];
            end
            if (bus.done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (bus.busy) busy_cnt++;
            for (int t = 0; t < int'(NUM_COL); t++) begin
                if (t >= n) begin
                    bus.tag_lock_in[t] = 1'($urandom_range(0, 1));
                end else if (sched[t] == c) begin
                    bus.tag_lock_in[t] = 1'b1;
                    if (t + 1 == abort_tag) bus.abort = 1'b1;
                end
            end
        end while (c < exp_end + 3);
        bus.abort = 1'b0;
        bus.start = 1'b0;

        check_eq({name, " flush_count"}, obs_fc.size(), exp_fc.size());
        for (int i = 0; i < obs_fc.size() && i < exp_fc.size(); i++) begin
            check_eq($sformatf("%s flush%0d_cycle", name, i), obs_fc[i] - T, exp_fc[i] - T);
            check_eq($sformatf("%s flush%0d_tag", name, i), obs_ft[i], exp_ft[i]);
        end
        check_eq({name, " done_count"}, done_cnt, (exp_done >= 0) ? 1 : 0);
        if (exp_done >= 0 && done_cnt > 0)
            check_eq({name, " done_cycle"}, done_cyc - T, exp_done - T);
        check_eq({name, " busy_cycles"}, busy_cnt, exp_end - T);
        check_eq({name, " err"}, bus.err, exp_err);
        check_eq({name, " tag_out_hold"}, bus.tag_out, model_last_tag);
        check_eq({name, " busy_end"}, bus.busy, 0);
    endtask

    // Pulse reset mid-cycle, away from the clock edge, and check the outputs
    // clear without waiting for a clock.
    task automatic reset_pulse(input string name, input int exp_busy_before);
        @(posedge clk);
        #2;
        check_eq({name, " busy_before"}, bus.busy, exp_busy_before);
        rstn = 1'b0;
        #1;
        check_eq({name, " flush_tag"}, bus.flush_tag, 0);
        check_eq({name, " tag_out"}, bus.tag_out, 0);
        check_eq({name, " busy"}, bus.busy, 0);
        check_eq({name, " done"}, bus.done, 0);
        check_eq({name, " err"}, bus.err, 0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        model_last_tag = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dl[4];
        int nt, a, r, abort_tag;

        bus.start       = 1'b0;
        bus.num_tags    = '0;
        bus.abort       = 1'b0;
        bus.tag_lock_in = '0;

        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check_eq("reset flush_tag", bus.flush_tag, 0);
        check_eq("reset tag_out", bus.tag_out, 0);
        check_eq("reset busy", bus.busy, 0);
        check_eq("reset done", bus.done, 0);
        check_eq("reset err", bus.err, 0);

        run_seq("three_tags", 3, '{2, 2, 2, 2}, 0);
        run_seq("clamp", 7, '{1, 1, 1, 1}, 0);
        run_seq("zero_tags", 0, '{1, 1, 1, 1}, 0);
        run_seq("timeout", 3, '{2, 0, 2, 2}, 0);
        @(negedge clk);
        check_eq("timeout err_sticky", bus.err, 1);
        run_seq("after_timeout", 2, '{3, 1, 1, 1}, 0);
        run_seq("lock_last_wait", 1, '{15, 1, 1, 1}, 0);
        run_seq("lock_too_late", 1, '{16, 1, 1, 1}, 0);
        reset_pulse("rst_idle", 0);
        run_seq("abort_on_lock", 4, '{1, 3, 1, 1}, 2);

        @(negedge clk);
        bus.num_tags    = TAG_W'(4);
        bus.start       = 1'b1;
        bus.tag_lock_in = '0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_wait tag_before", bus.tag_out, 1);
        reset_pulse("rst_wait", 1);
        run_seq("after_reset", 2, '{2, 2, 2, 2}, 0);

        for (int k = 0; k < 40; k++) begin
            nt = $urandom_range(0, 7);
            for (int i = 0; i < 4; i++) begin
                r = $urandom_range(0, 19);
                if (r == 0)      dl[i] = 0;
                else if (r == 1) dl[i] = 15;
                else if (r == 2) dl[i] = 16;
                else             dl[i] = $urandom_range(1, 5);
            end
            abort_tag = 0;
            if ($urandom_range(0, 4) == 0) begin
                a = $urandom_range(1, 4);
                if (dl[a-1] >= 1 && dl[a-1] <= int'(TIMEOUT) - 1) abort_tag = a;
            end
            run_seq($sformatf("rand%0d", k), nt, dl, abort_tag);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
